// File: rtl/mmm_nlp_iter_wd.sv
// Digit-serial Montgomery multiplier: o_res = a*b*2^-DW mod m, fully reduced.
// One WW-bit digit of a per MUL/RED pair, then a single conditional subtraction.
module mmm_nlp_iter_wd #(
   parameter  int DW = 256,
   parameter  int WW = 64,
   localparam int NW = DW / WW
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_vld,
   output logic          o_rdy,
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   input  logic [DW-1:0] i_m,
   input  logic [WW-1:0] i_m_inv,
   output logic          o_vld,
   input  logic          i_rdy,
   output logic [DW-1:0] o_res,
   output logic          o_busy
);

   localparam int TW = DW + WW + 2;
   localparam int IW = (NW > 1) ? $clog2(NW) : 1;

   generate
      if ((DW % WW) != 0) begin : g_bad_cfg
         $error("mmm_nlp_iter_wd: DW must be a multiple of WW");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_RED, S_CORR, S_DONE} state_t;

   state_t        r_state, w_next;
   logic [DW-1:0] r_a, r_b, r_m, r_res;
   logic [WW-1:0] r_minv;
   logic [TW-1:0] r_t;
   logic [IW-1:0] r_i;
   logic          r_vld;

   logic          w_acc, w_last, w_ge;
   logic [WW-1:0] w_digit, w_q;
   logic [TW-1:0] w_mul, w_red;

   assign o_rdy  = (r_state == S_IDLE) & ~i_rst;
   assign o_busy = (r_state != S_IDLE);
   assign o_vld  = r_vld;
   assign o_res  = r_res;

   assign w_acc   = i_vld & o_rdy;
   assign w_last  = (r_i == IW'(NW - 1));
   assign w_digit = r_a[r_i*WW +: WW];
   assign w_mul   = r_t + TW'(w_digit) * TW'(r_b);
   // q zeroes the low digit of T + q*m, so the shift drops only zero bits
   assign w_q     = r_t[WW-1:0] * r_minv;
   assign w_red   = (r_t + TW'(w_q) * TW'(r_m)) >> WW;
   assign w_ge    = (r_t >= TW'(r_m));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_acc) w_next = S_MUL;
         S_MUL:   w_next = S_RED;
         S_RED:   w_next = w_last ? S_CORR : S_MUL;
         S_CORR:  w_next = S_DONE;
         S_DONE:  if (r_vld & i_rdy) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_m    <= '0;
         r_minv <= '0;
         r_t    <= '0;
         r_i    <= '0;
         r_res  <= '0;
         r_vld  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: if (w_acc) begin
               r_a    <= i_a;
               r_b    <= i_b;
               r_m    <= i_m;
               r_minv <= i_m_inv;
               r_t    <= '0;
               r_i    <= '0;
            end
            S_MUL: r_t <= w_mul;
            S_RED: begin
               r_t <= w_red;
               if (!w_last) r_i <= r_i + 1'b1;
            end
            S_CORR: begin
               // T < 2m here, so one subtraction fully reduces
               r_res <= w_ge ? DW'(r_t - TW'(r_m)) : r_t[DW-1:0];
               r_vld <= 1'b1;
            end
            S_DONE: if (i_rdy) r_vld <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mmm_nlp_iter_wd.sv
// Bench for mmm_nlp_iter_wd: a 16/8 instance and a default 256/64 instance,
// scored against a bit-serial Montgomery reference model.
module tb_mmm_nlp_iter_wd;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   localparam logic [255:0] PM   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
   localparam logic [63:0]  PINV = 64'hD838091DD2253531;

   // small instance
   logic        s_vld, s_rdy, s_ordy, s_ovld, s_busy;
   logic [15:0] s_a, s_b, s_m, s_res;
   logic [7:0]  s_mi;
   // default instance
   logic         d_vld, d_rdy, d_ordy, d_ovld, d_busy;
   logic [255:0] d_a, d_b, d_m, d_res;
   logic [63:0]  d_mi;

   mmm_nlp_iter_wd #(.DW(16), .WW(8)) u_s (
      .i_clk(clk), .i_rst(rst), .i_vld(s_vld), .o_rdy(s_ordy),
      .i_a(s_a), .i_b(s_b), .i_m(s_m), .i_m_inv(s_mi),
      .o_vld(s_ovld), .i_rdy(s_rdy), .o_res(s_res), .o_busy(s_busy));

   mmm_nlp_iter_wd u_d (
      .i_clk(clk), .i_rst(rst), .i_vld(d_vld), .o_rdy(d_ordy),
      .i_a(d_a), .i_b(d_b), .i_m(d_m), .i_m_inv(d_mi),
      .o_vld(d_ovld), .i_rdy(d_rdy), .o_res(d_res), .o_busy(d_busy));

   typedef struct {
      logic [255:0] exp;
      logic [255:0] m;
   } sb_t;

   sb_t q_s[$];
   sb_t q_d[$];
   int  total = 0;
   int  bad   = 0;
   int  s_pops = 0;
   bit  s_acc, d_acc;

   // Bit-serial REDC: halve dw times, adding m whenever odd, then reduce once.
   function automatic logic [255:0] mont(input logic [255:0] a, b, m, input int dw);
      logic [513:0] r;
      r = 514'(a) * 514'(b);
      for (int k = 0; k < dw; k++) begin
         if (r[0]) r = r + 514'(m);
         r = r >> 1;
      end
      if (r >= 514'(m)) r = r - 514'(m);
      return r[255:0];
   endfunction

   function automatic logic [7:0] minv8(input logic [15:0] m);
      logic [7:0] kk, p;
      for (int k = 0; k < 256; k++) begin
         kk = 8'(k);
         p  = m[7:0] * kk;
         if (p == 8'hFF) return kk;
      end
      return 8'h00;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r = '0;
      for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom())};
      if (r >= PM) r = r - PM;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes mid-cycle, then advance past the edge.
   task automatic step();
      sb_t e;
      @(negedge clk);
      s_acc = 1'b0;
      d_acc = 1'b0;
      if (s_vld && s_ordy) begin
         s_acc = 1'b1;
         e.exp = mont(256'(s_a), 256'(s_b), 256'(s_m), 16);
         e.m   = 256'(s_m);
         q_s.push_back(e);
      end
      if (d_vld && d_ordy) begin
         d_acc = 1'b1;
         e.exp = mont(d_a, d_b, d_m, 256);
         e.m   = d_m;
         q_d.push_back(e);
      end
      if (s_ovld && s_rdy) begin
         chk("s_not_spurious", 256'(q_s.size() != 0), 256'd1);
         if (q_s.size() != 0) begin
            e = q_s.pop_front();
            s_pops++;
            chk("s_res", 256'(s_res), e.exp);
            chk("s_res_lt_m", 256'(256'(s_res) < e.m), 256'd1);
         end
      end
      if (d_ovld && d_rdy) begin
         chk("d_not_spurious", 256'(q_d.size() != 0), 256'd1);
         if (q_d.size() != 0) begin
            e = q_d.pop_front();
            chk("d_res", d_res, e.exp);
            chk("d_res_lt_m", 256'(d_res < e.m), 256'd1);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic s_req(input logic [15:0] a, b, m, input logic [7:0] mi);
      int n = 0;
      s_a = a; s_b = b; s_m = m; s_mi = mi; s_vld = 1'b1;
      do begin step(); n++; end while (!s_acc && n < 100);
      s_vld = 1'b0;
      chk("s_accept", 256'(s_acc), 256'd1);
   endtask

   task automatic d_req(input logic [255:0] a, b);
      int n = 0;
      d_a = a; d_b = b; d_m = PM; d_mi = PINV; d_vld = 1'b1;
      do begin step(); n++; end while (!d_acc && n < 100);
      d_vld = 1'b0;
      chk("d_accept", 256'(d_acc), 256'd1);
   endtask

   task automatic drain();
      int n = 0;
      while ((q_s.size() != 0 || q_d.size() != 0) && n < 500) begin step(); n++; end
      chk("drain_empty", 256'(q_s.size() + q_d.size()), 256'd0);
   endtask

   initial begin
      logic [255:0] bb;
      int issued, n, vld_seen;
      logic [15:0] rm;
      s_vld = 0; s_rdy = 1; s_a = 0; s_b = 0; s_m = 16'hFFF1; s_mi = 8'hEF;
      d_vld = 0; d_rdy = 1; d_a = 0; d_b = 0; d_m = PM; d_mi = PINV;

      // reset state while held
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ovld", 256'(s_ovld), 256'd0);
      chk("rst_s_res", 256'(s_res), 256'd0);
      chk("rst_s_busy", 256'(s_busy), 256'd0);
      chk("rst_s_ordy", 256'(s_ordy), 256'd0);
      chk("rst_d_ovld", 256'(d_ovld), 256'd0);
      chk("rst_d_res", d_res, 256'd0);
      chk("rst_d_ordy", 256'(d_ordy), 256'd0);
      rst = 1'b0;
      #1;
      chk("rel_s_ordy", 256'(s_ordy), 256'd1);
      chk("rel_d_ordy", 256'(d_ordy), 256'd1);

      // R mod m times b returns b; latency 2*NW+1 = 5
      s_req(16'h000F, 16'h1234, 16'hFFF1, 8'hEF);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("t1_latency", 256'(s_ovld), 256'(k == 5));
      end
      chk("t1_res", 256'(s_res), 256'h1234);
      chk("t1_busy", 256'(s_busy), 256'd1);
      drain();
      chk("t1_res_held", 256'(s_res), 256'h1234);
      chk("t1_vld_low", 256'(s_ovld), 256'd0);

      // R^2 mod m -> R mod m; largest b exercises the final subtraction
      s_req(16'h00E1, 16'h0001, 16'hFFF1, 8'hEF);
      drain();
      chk("t2_r2", 256'(s_res), 256'h000F);
      s_req(16'h000F, 16'hFFF0, 16'hFFF1, 8'hEF);
      drain();
      chk("t2_max", 256'(s_res), 256'hFFF0);
      s_req(16'h0000, 16'h1234, 16'hFFF1, 8'hEF);
      drain();
      chk("t2_zero", 256'(s_res), 256'd0);

      // default 256/64 config, latency 9
      bb = rnd256();
      d_req(256'h1000003D1, bb);
      for (int k = 1; k <= 9; k++) begin
         step();
         chk("t3_latency", 256'(d_ovld), 256'(k == 9));
      end
      drain();
      chk("t3_identity", d_res, bb);
      d_req(256'd0, rnd256());
      drain();
      chk("t3_zero", d_res, 256'd0);
      for (int r = 0; r < 8; r++) begin
         d_req(rnd256(), rnd256());
         drain();
      end

      // backpressure: DONE holds, new requests are ignored
      s_rdy = 1'b0;
      s_req(16'h000F, 16'h0ABC, 16'hFFF1, 8'hEF);
      n = 0;
      while (!s_ovld && n < 20) begin step(); n++; end
      chk("t4_vld_up", 256'(s_ovld), 256'd1);
      for (int k = 0; k < 20; k++) begin
         s_vld = 1'($urandom_range(1));
         s_a   = 16'($urandom_range(16'hFFF0));
         step();
         chk("t4_vld_hold", 256'(s_ovld), 256'd1);
         chk("t4_res_hold", 256'(s_res), 256'h0ABC);
         chk("t4_rdy_low", 256'(s_ordy), 256'd0);
      end
      s_vld = 1'b0;
      s_rdy = 1'b1;
      step();
      chk("t4_idle_rdy", 256'(s_ordy), 256'd1);
      chk("t4_idle_vld", 256'(s_ovld), 256'd0);
      chk("t4_sb_empty", 256'(q_s.size()), 256'd0);

      // reset in the 4th cycle after accept aborts the request
      s_req(16'h000F, 16'h1111, 16'hFFF1, 8'hEF);
      repeat (3) step();
      rst = 1'b1;
      #1;
      chk("t5_rst_rdy", 256'(s_ordy), 256'd0);
      chk("t5_rst_busy", 256'(s_busy), 256'd0);
      q_s.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("t5_rel_rdy", 256'(s_ordy), 256'd1);
      chk("t5_rel_busy", 256'(s_busy), 256'd0);
      vld_seen = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (s_ovld) vld_seen++;
      end
      chk("t5_no_vld", 256'(vld_seen), 256'd0);
      s_req(16'h00E1, 16'h0002, 16'hFFF1, 8'hEF);
      drain();
      chk("t5_after", 256'(s_res), 256'h001E);

      // random stream with random handshakes and moduli
      issued = 0; n = 0; s_pops = 0;
      while ((issued < 1000 || q_s.size() != 0 || s_vld) && n < 60000) begin
         if (!s_vld && issued < 1000 && $urandom_range(3) != 0) begin
            rm    = (16'($urandom_range(16'h7FFF, 1)) << 1) | 16'd1;
            s_m   = rm;
            s_mi  = minv8(rm);
            s_a   = ($urandom_range(7) == 0) ? rm - 16'd1 : 16'($urandom_range(int'(rm) - 1));
            s_b   = ($urandom_range(7) == 0) ? rm - 16'd1 : 16'($urandom_range(int'(rm) - 1));
            s_vld = 1'b1;
         end
         s_rdy = ($urandom_range(3) != 0);
         step();
         n++;
         if (s_acc) begin s_vld = 1'b0; issued++; end
      end
      chk("t6_issued", 256'(issued), 256'd1000);
      chk("t6_results", 256'(s_pops), 256'd1000);
      chk("t6_sb_empty", 256'(q_s.size()), 256'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
